// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny DNN MAC array.
// Holds the parameter defaults used by the array and its per-filter lanes,
// and the controller state encoding.
package tiny_dnn_pkg;

  localparam int DEF_F_NUM = 16;  // filters (accumulators)
  localparam int DEF_LANES = 4;   // weight words per write beat
  localparam int DEF_DW    = 16;  // signed fixed-point data/weight width
  localparam int DEF_FRAC  = 8;   // fractional bits of data and weights
  localparam int DEF_AW    = 10;  // weight address width
  localparam int DEF_ACC_W = 40;  // accumulator width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/tiny_dnn_mac_lane.sv
// One filter of the MAC array: weight RAM, bias register, 2-stage MAC and
// accumulator.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pipe/accumulator only)
//   w_we_i        write w_data_i into the weight RAM at w_addr_i
//   b_we_i        write w_data_i into the bias register
//   w_addr_i      weight write address
//   w_data_i      weight / bias write word
//   clr_i         start a new pass: accumulator restarts from this cycle's terms
//   exec_i        accumulate d_i * w[ra_i]
//   bias_i        accumulate bias << FRAC
//   ra_i          weight read address
//   d_i           signed activation
//   acc_o         accumulator value
module tiny_dnn_mac_lane
  import tiny_dnn_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int FRAC  = DEF_FRAC,
  parameter int AW    = DEF_AW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_we_i,
  input  logic             b_we_i,
  input  logic [AW-1:0]    w_addr_i,
  input  logic [DW-1:0]    w_data_i,
  input  logic             clr_i,
  input  logic             exec_i,
  input  logic             bias_i,
  input  logic [AW-1:0]    ra_i,
  input  logic [DW-1:0]    d_i,
  output logic [ACC_W-1:0] acc_o
);

  logic signed [DW-1:0]    mem_q [2**AW];
  logic signed [DW-1:0]    w_q;
  logic signed [DW-1:0]    d_q;
  logic signed [DW-1:0]    bias_reg_q;
  logic                    exec_s1_q;
  logic                    bias_s1_q;
  logic                    clr_s1_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] term_d;
  logic signed [ACC_W-1:0] bias_ext;

  // Storage is not reset: weights and bias survive rst between passes.
  always_ff @(posedge clk) begin
    if (w_we_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
    if (b_we_i) begin
      bias_reg_q <= w_data_i;
    end
    // Stage 1: synchronous weight read alongside the activation.
    w_q <= mem_q[ra_i];
    d_q <= d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_s1_q <= 1'b0;
      bias_s1_q <= 1'b0;
      clr_s1_q  <= 1'b0;
      acc_q     <= '0;
    end else begin
      exec_s1_q <= exec_i;
      bias_s1_q <= bias_i;
      clr_s1_q  <= clr_i;
      acc_q     <= acc_d;
    end
  end

  // Stage 2: sign-extended product and bias terms; the clear travels with
  // the terms so a clear cycle's own exec/bias become the first addends and
  // anything still in flight from the previous pass is dropped.
  always_comb begin
    prod     = d_q * w_q;
    bias_ext = ACC_W'(bias_reg_q);
    term_d   = '0;
    if (exec_s1_q) begin
      term_d = term_d + ACC_W'(prod);
    end
    if (bias_s1_q) begin
      term_d = term_d + (bias_ext <<< FRAC);
    end
    acc_d = acc_q;
    if (clr_s1_q) begin
      acc_d = term_d;
    end else if (exec_s1_q || bias_s1_q) begin
      acc_d = acc_q + term_d;  // wraps modulo 2**ACC_W
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/tiny_dnn_mac_array.sv
// Array of F_NUM MAC lanes sharing one activation stream, with a beat-wise
// weight/bias loader and a drain port that streams saturated results.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   init                clear accumulators and start a pass
//   exec, bias          accumulate d*w[ra] / bias<<FRAC (only during a pass)
//   ra, d               weight read address, signed activation
//   wr_valid/wr_ready   weight/bias write handshake (ready only when idle)
//   wr_data             LANES words, lane k at bits k*DW+:DW
//   wr_addr, wr_bias    weight address, or select bias registers instead
//   out_start           snapshot accumulators and drain them
//   dst_valid/ready     result handshake
//   dst_data/idx/last   saturated result, filter index, last-filter flag
//   busy                high whenever not idle
module tiny_dnn_mac_array
  import tiny_dnn_pkg::*;
#(
  parameter int F_NUM = DEF_F_NUM,
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int FRAC  = DEF_FRAC,
  parameter int AW    = DEF_AW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     exec,
  input  logic                     bias,
  input  logic [AW-1:0]            ra,
  input  logic [DW-1:0]            d,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [LANES*DW-1:0]      wr_data,
  input  logic [AW-1:0]            wr_addr,
  input  logic                     wr_bias,
  input  logic                     out_start,
  output logic                     dst_valid,
  output logic [DW-1:0]            dst_data,
  output logic [$clog2(F_NUM)-1:0] dst_idx,
  output logic                     dst_last,
  input  logic                     dst_ready,
  output logic                     busy
);

  localparam int GRP_N = F_NUM / LANES;
  localparam int GW    = (GRP_N > 1) ? $clog2(GRP_N) : 1;
  localparam int IDX_W = $clog2(F_NUM);

  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e           state_q;
  logic [GW-1:0]    grp_q;
  logic             flush_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] nxt_idx;
  logic             dst_valid_q;
  logic [DW-1:0]    dst_data_q;
  logic             dst_last_q;

  logic             beat;
  logic             acc_en;
  logic             lane_clr;
  logic             lane_exec;
  logic             lane_bias;
  logic [ACC_W-1:0] acc_all [F_NUM];

  // Drop FRAC bits (arithmetic) and clamp to the signed DW range.
  function automatic logic [DW-1:0] sat_out(input logic [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = $signed(a) >>> FRAC;
    if (sh > SAT_MAX) begin
      sh = SAT_MAX;
    end else if (sh < SAT_MIN) begin
      sh = SAT_MIN;
    end
    return sh[DW-1:0];
  endfunction

  assign wr_ready = (state_q == ST_IDLE);
  assign beat     = wr_valid && wr_ready;
  assign busy     = (state_q != ST_IDLE);

  // The init cycle itself counts as part of the pass, so exec/bias arriving
  // with init from IDLE are accumulated as first terms.
  assign acc_en    = (state_q == ST_ACC) || ((state_q == ST_IDLE) && init);
  assign lane_clr  = init && acc_en;
  assign lane_exec = exec && acc_en;
  assign lane_bias = bias && acc_en;

  assign nxt_idx = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grp_q       <= '0;
      flush_q     <= 1'b0;
      idx_q       <= '0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      dst_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            grp_q   <= '0;
            state_q <= ST_ACC;
          end else if (beat) begin
            grp_q <= (grp_q == GW'(GRP_N - 1)) ? '0 : grp_q + 1'b1;
          end
        end
        ST_ACC: begin
          // A re-init wins over a simultaneous snapshot request.
          if (init) begin
            grp_q <= '0;
          end else if (out_start) begin
            flush_q <= 1'b0;
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Two cycles let the last exec reach the accumulators.
          if (flush_q) begin
            state_q     <= ST_DRAIN;
            idx_q       <= '0;
            dst_valid_q <= 1'b1;
            dst_data_q  <= sat_out(acc_all[0]);
            dst_last_q  <= (F_NUM == 1);
          end else begin
            flush_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dst_valid_q && dst_ready) begin
            if (dst_last_q) begin
              state_q     <= ST_IDLE;
              idx_q       <= '0;
              dst_valid_q <= 1'b0;
              dst_last_q  <= 1'b0;
            end else begin
              idx_q      <= nxt_idx;
              dst_data_q <= sat_out(acc_all[nxt_idx]);
              dst_last_q <= (nxt_idx == IDX_W'(F_NUM - 1));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;
  assign dst_idx   = idx_q;
  assign dst_last  = dst_last_q;

  // Filter gi takes lane gi%LANES of beats issued while the group counter
  // equals gi/LANES.
  for (genvar gi = 0; gi < F_NUM; gi++) begin : g_lane
    localparam int GRP = gi / LANES;
    localparam int LN  = gi % LANES;
    logic sel;
    assign sel = beat && (grp_q == GW'(GRP));

    tiny_dnn_mac_lane #(
      .DW    (DW),
      .FRAC  (FRAC),
      .AW    (AW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .w_we_i   (sel && !wr_bias),
      .b_we_i   (sel && wr_bias),
      .w_addr_i (wr_addr),
      .w_data_i (wr_data[LN*DW +: DW]),
      .clr_i    (lane_clr),
      .exec_i   (lane_exec),
      .bias_i   (lane_bias),
      .ra_i     (ra),
      .d_i      (d),
      .acc_o    (acc_all[gi])
    );
  end

endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
// Self-checking bench for tiny_dnn_mac_array with default parameters.
module tb_tiny_dnn_mac_array;

  localparam int F_NUM = 16;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int AW    = 10;
  localparam int ACC_W = 40;
  localparam int IW    = 4;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } out_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                init = 1'b0;
  logic                exec = 1'b0;
  logic                bias = 1'b0;
  logic [AW-1:0]       ra = '0;
  logic [DW-1:0]       d = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [LANES*DW-1:0] wr_data = '0;
  logic [AW-1:0]       wr_addr = '0;
  logic                wr_bias = 1'b0;
  logic                out_start = 1'b0;
  logic                dst_valid;
  logic [DW-1:0]       dst_data;
  logic [IW-1:0]       dst_idx;
  logic                dst_last;
  logic                dst_ready = 1'b0;
  logic                busy;

  int   n_cmp = 0;
  int   n_fail = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  logic [DW-1:0] lane_w [F_NUM];

  always #5 clk = ~clk;

  tiny_dnn_mac_array #(
    .F_NUM(F_NUM), .LANES(LANES), .DW(DW), .FRAC(FRAC), .AW(AW), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .exec(exec), .bias(bias), .ra(ra), .d(d),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_bias(wr_bias), .out_start(out_start), .dst_valid(dst_valid),
    .dst_data(dst_data), .dst_idx(dst_idx), .dst_last(dst_last),
    .dst_ready(dst_ready), .busy(busy)
  );

  // Reference: n identical products, FRAC shift, clamp to 16-bit signed.
  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] dv,
                                              input logic [DW-1:0] wv, input int n);
    longint a;
    longint s;
    a = longint'($signed(dv)) * longint'($signed(wv)) * longint'(n);
    s = a >>> FRAC;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [AW-1:0] addr, input logic [LANES*DW-1:0] data,
                            input logic isb);
    wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_bias = isb;
    tick();
    wr_valid = 1'b0; wr_bias = 1'b0;
  endtask

  task automatic fill_all(input logic [AW-1:0] addr, input logic [DW-1:0] v, input logic isb);
    for (int g = 0; g < F_NUM / LANES; g++) write_beat(addr, {LANES{v}}, isb);
  endtask

  task automatic do_init(input logic with_bias);
    init = 1'b1; bias = with_bias;
    tick();
    init = 1'b0; bias = 1'b0;
  endtask

  task automatic do_exec(input logic [AW-1:0] a, input logic [DW-1:0] dv, input int n);
    exec = 1'b1; ra = a; d = dv;
    repeat (n) tick();
    exec = 1'b0;
  endtask

  task automatic do_out();
    out_start = 1'b1;
    tick();
    out_start = 1'b0;
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    for (int i = 0; i < F_NUM; i++) exp_q.push_back('{(i == F_NUM - 1), IW'(i), v});
  endtask

  // Collects drained results into obs_q; stops on last or cycle budget.
  task automatic drain_all(input int budget);
    int  cyc = 0;
    bit  done = 0;
    dst_ready = 1'b1;
    while (!done && cyc < budget) begin
      if (dst_valid) begin
        obs_q.push_back('{dst_last, dst_idx, dst_data});
        $display("tb: out idx=%0d data=%h last=%b", dst_idx, dst_data, dst_last);
        if (dst_last) done = 1;
      end
      tick();
      cyc++;
    end
    dst_ready = 1'b0;
  endtask

  task automatic test_reset();
    out_t o;
    rst = 1'b1;
    repeat (3) tick();
    o = '{dst_last, dst_idx, dst_data};
    n_cmp++;
    if (dst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", dst_valid); end
    n_cmp++;
    if (o !== out_t'(0)) begin n_fail++; $display("FAIL rst_outs got=%h want=0", o); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready got=%b want=1", wr_ready); end
    do_out();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_out_start busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    out_t e, o;
    fill_all(10'd5, 16'h0100, 1'b0);
    do_init(1'b0);
    do_exec(10'd5, 16'h0200, 3);
    do_out();
    push_const(16'h0600);
    drain_all(100);
    n_cmp++;
    if (obs_q.size() != F_NUM) begin n_fail++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL basic_out got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b", o.idx, o.data, o.last, e.idx, e.data, e.last); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bias();
    out_t e, o;
    fill_all(10'd0, 16'h0080, 1'b1);
    do_init(1'b1);
    do_exec(10'd5, 16'h0100, 1);
    do_out();
    push_const(16'h0180);
    drain_all(100);
    n_cmp++;
    if (obs_q.size() != F_NUM) begin n_fail++; $display("FAIL bias_count got=%0d want=%0d", obs_q.size(), F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL bias_out got idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clamp();
    out_t e, o;
    fill_all(10'd7, 16'h7FFF, 1'b0);
    do_init(1'b0);
    do_exec(10'd7, 16'h7FFF, 200);
    do_out();
    push_const(16'h7FFF);
    drain_all(100);
    do_init(1'b0);
    do_exec(10'd7, 16'h8000, 200);
    do_out();
    push_const(16'h8000);
    drain_all(100);
    n_cmp++;
    if (obs_q.size() != 2 * F_NUM) begin n_fail++; $display("FAIL clamp_count got=%0d want=%0d", obs_q.size(), 2 * F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL clamp_out got idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_pressure();
    out_t e, o;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;
    int cyc = 0;
    bit stalled = 0;
    bit done = 0;
    do_init(1'b0);
    do_exec(10'd5, 16'h0200, 3);
    do_out();
    push_const(16'h0600);
    dst_ready = 1'b1;
    while (!done && cyc < 200) begin
      if (dst_valid) begin
        if (dst_idx == 7 && !stalled) begin
          dst_ready = 1'b0; hold_d = dst_data; hold_i = dst_idx;
          for (int k = 0; k < 5; k++) begin
            tick(); cyc++; n_cmp++;
            if (!dst_valid || dst_data !== hold_d || dst_idx !== hold_i) begin
              n_fail++;
              $display("FAIL stall_hold got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", dst_valid, dst_idx, dst_data, hold_i, hold_d);
            end
          end
          stalled = 1; dst_ready = 1'b1;
        end
        obs_q.push_back('{dst_last, dst_idx, dst_data});
        $display("tb: out idx=%0d data=%h last=%b", dst_idx, dst_data, dst_last);
        if (dst_last) done = 1;
      end
      tick(); cyc++;
    end
    dst_ready = 1'b0;
    n_cmp++;
    if (!stalled) begin n_fail++; $display("FAIL stall_reached got=0 want=1"); end
    n_cmp++;
    if (obs_q.size() != F_NUM) begin n_fail++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall_out got idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lane_write();
    out_t e, o;
    logic [LANES*DW-1:0] beat;
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL lane_wr_ready_idle got=%b want=1", wr_ready); end
    for (int f = 0; f < F_NUM; f++) lane_w[f] = DW'((f - 8) * 64);
    for (int g = 0; g < F_NUM / LANES; g++) begin
      for (int k = 0; k < LANES; k++) beat[k*DW +: DW] = lane_w[g*LANES + k];
      write_beat(10'd9, beat, 1'b0);
    end
    do_init(1'b0);
    n_cmp++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lane_busy got ready=%b busy=%b want ready=0 busy=1", wr_ready, busy); end
    do_exec(10'd9, 16'h0180, 1);
    do_out();
    for (int f = 0; f < F_NUM; f++) exp_q.push_back('{(f == F_NUM - 1), IW'(f), model_out(16'h0180, lane_w[f], 1)});
    drain_all(100);
    n_cmp++;
    if (obs_q.size() != F_NUM) begin n_fail++; $display("FAIL lane_count got=%0d want=%0d", obs_q.size(), F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL lane_out got idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_rst_drain();
    out_t e, o;
    int cyc = 0;
    do_init(1'b0);
    do_exec(10'd9, 16'h0100, 1);
    do_out();
    dst_ready = 1'b1;
    while (!(dst_valid && dst_idx == 3) && cyc < 100) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (!(dst_valid && dst_idx == 3)) begin n_fail++; $display("FAIL rstd_reach got idx=%0d want=3", dst_idx); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dst_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstd_immediate got valid=%b busy=%b want 0 0", dst_valid, busy); end
    dst_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (wr_ready !== 1'b1 || dst_idx !== '0) begin n_fail++; $display("FAIL rstd_idle got ready=%b idx=%0d want ready=1 idx=0", wr_ready, dst_idx); end
    do_init(1'b0);
    do_exec(10'd9, 16'h0100, 1);
    do_out();
    for (int f = 0; f < F_NUM; f++) exp_q.push_back('{(f == F_NUM - 1), IW'(f), model_out(16'h0100, lane_w[f], 1)});
    drain_all(100);
    n_cmp++;
    if (obs_q.size() != F_NUM) begin n_fail++; $display("FAIL rstd_count got=%0d want=%0d", obs_q.size(), F_NUM); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rstd_out got idx=%0d data=%h want idx=%0d data=%h", o.idx, o.data, e.idx, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_clamp();
    test_back_pressure();
    test_lane_write();
    test_rst_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
